// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: instruction-fetch sequencer for a PC register that lives
// outside this block.
//
// The PC register self-increments by 4 when pc_write is low. This block
// drives pc_write high in every cycle and steers pc_next itself, so the PC
// only moves when the fetch sequence or a redirect says so.
//
// Configuration macro:
//   PC_MISALIGN_TRAP_EN  defined   : a misaligned jump/branch target redirects
//                                    to EXC_VECTOR and pulses misalign_trap.
//                        undefined : target bits [1:0] are forced to 00 and
//                                    misalign_trap is tied low.
//
// Ports:
//   clk, reset               clock; asynchronous active-high reset
//   pc_cur                   current PC register value
//   pc_write, pc_next        PC load enable (always 1) and load value
//   exc_valid                exception redirect to EXC_VECTOR (highest priority)
//   jump_valid, jump_target  jump redirect
//   br_valid, br_target      taken-branch redirect (lowest priority)
//   stall                    decode hazard; holds the fetched instruction
//   imem_req, imem_addr      memory request and address
//   imem_ready               memory accepts the request this cycle
//   imem_rvalid, imem_rdata  memory response
//   if_valid, if_instr, if_pc  instruction handed to decode
//   flush                    kills the younger instruction in decode
//   misalign_trap            misaligned redirect target trapped
//   dbg_state                current FSM state (BOOT=0, REQ=1, WAIT=2, STALL=3)
//
// Handshake: a request transfers in a cycle where imem_req and imem_ready are
// both 1; exactly one response (imem_rvalid for one cycle) follows in a later
// cycle, and imem_rvalid is only honoured while the FSM is in WAIT.
module pc_fetch_ctrl #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR   = ADDR_WIDTH'(32'h80)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc_cur,
  output logic                  pc_write,
  output logic [ADDR_WIDTH-1:0] pc_next,
  input  logic                  exc_valid,
  input  logic                  jump_valid,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  input  logic                  br_valid,
  input  logic [ADDR_WIDTH-1:0] br_target,
  input  logic                  stall,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic                  imem_rvalid,
  input  logic [31:0]           imem_rdata,
  output logic                  if_valid,
  output logic [31:0]           if_instr,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic                  flush,
  output logic                  misalign_trap,
  output logic [1:0]            dbg_state
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_STALL = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  discard_q, discard_d;
  logic [31:0]           instr_q;
  logic [ADDR_WIDTH-1:0] ipc_q;
  logic                  capture;

  logic                  redir;
  logic [ADDR_WIDTH-1:0] raw_tgt;
  logic [ADDR_WIDTH-1:0] redir_tgt;
  logic                  redir_trap;
  logic [ADDR_WIDTH-1:0] pc_plus4;

  // Wraps naturally at ADDR_WIDTH bits.
  assign pc_plus4  = pc_cur + ADDR_WIDTH'(4);
  assign pc_write  = 1'b1;
  assign dbg_state = state_q;
  assign redir     = exc_valid | jump_valid | br_valid;

  // Priority select: exception, then jump, then branch.
  always_comb begin
    raw_tgt = br_target;
    if (exc_valid)       raw_tgt = EXC_VECTOR;
    else if (jump_valid) raw_tgt = jump_target;
  end

`ifdef PC_MISALIGN_TRAP_EN
  // The exception vector is trusted; only jump/branch targets are checked.
  always_comb begin
    redir_trap = !exc_valid && (raw_tgt[1:0] != 2'b00);
    redir_tgt  = redir_trap ? EXC_VECTOR : raw_tgt;
  end
  assign misalign_trap = flush & redir_trap;
`else
  always_comb begin
    redir_trap = 1'b0;
    redir_tgt  = raw_tgt & ~ADDR_WIDTH'(3);
  end
  assign misalign_trap = redir_trap;
`endif

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    pc_next   = pc_cur;
    imem_req  = 1'b0;
    imem_addr = '0;
    if_valid  = 1'b0;
    if_instr  = '0;
    if_pc     = '0;
    flush     = 1'b0;
    capture   = 1'b0;
    case (state_q)
      S_BOOT: begin
        pc_next   = RESET_VECTOR;
        discard_d = 1'b0;
        state_d   = S_REQ;
      end
      S_REQ: begin
        imem_req  = 1'b1;
        imem_addr = pc_cur;
        if (imem_ready) state_d = S_WAIT;
        if (redir) begin
          pc_next = redir_tgt;
          flush   = 1'b1;
          // The request already accepted this cycle is for the old path.
          if (imem_ready) discard_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_REQ;
          if (discard_q) begin
            // pc_cur already holds the redirect target; refetch it unchanged.
            discard_d = 1'b0;
          end else begin
            if_valid = 1'b1;
            if_instr = imem_rdata;
            if_pc    = pc_cur;
            if (!redir) begin
              if (stall) begin
                state_d = S_STALL;
                capture = 1'b1;
              end else begin
                pc_next = pc_plus4;
              end
            end
          end
          if (redir) begin
            pc_next = redir_tgt;
            flush   = 1'b1;
          end
        end else if (redir) begin
          pc_next   = redir_tgt;
          flush     = 1'b1;
          discard_d = 1'b1;
        end
      end
      S_STALL: begin
        if_valid = 1'b1;
        if_instr = instr_q;
        if_pc    = ipc_q;
        if (redir) begin
          pc_next = redir_tgt;
          flush   = 1'b1;
          state_d = S_REQ;
        end else if (!stall) begin
          pc_next = pc_plus4;
          state_d = S_REQ;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_BOOT;
      discard_q <= 1'b0;
      instr_q   <= '0;
      ipc_q     <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      if (capture) begin
        instr_q <= imem_rdata;
        ipc_q   <= pc_cur;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd2;

`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [31:0] EXP_MIS_PC   = 32'h80;
  localparam logic [31:0] EXP_MIS_TRAP = 32'd1;
`else
  localparam logic [31:0] EXP_MIS_PC   = 32'h100;
  localparam logic [31:0] EXP_MIS_TRAP = 32'd0;
`endif

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [31:0] pc_cur, pc_next, jump_target, br_target, imem_addr, imem_rdata;
  logic [31:0] if_instr, if_pc;
  logic        pc_write, exc_valid, jump_valid, br_valid, stall;
  logic        imem_req, imem_ready, imem_rvalid, if_valid, flush, misalign_trap;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  pc_fetch_ctrl dut (
    .clk(clk), .reset(reset), .pc_cur(pc_cur), .pc_write(pc_write),
    .pc_next(pc_next), .exc_valid(exc_valid), .jump_valid(jump_valid),
    .jump_target(jump_target), .br_valid(br_valid), .br_target(br_target),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .flush(flush),
    .misalign_trap(misalign_trap), .dbg_state(dbg_state)
  );

  // External PC register; a non-zero reset value shows that BOOT loads it.
  logic [31:0] pc_reg;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         pc_reg <= 32'h0000_0F00;
    else if (pc_write) pc_reg <= pc_next;
    else               pc_reg <= pc_reg + 32'd4;
  end
  assign pc_cur = pc_reg;

  function automatic logic [31:0] instr_of(input logic [31:0] addr);
    return 32'hA500_0000 ^ addr;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; single-cycle request inputs drop after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    exc_valid   = 1'b0;
    jump_valid  = 1'b0;
    br_valid    = 1'b0;
  endtask

  task automatic req_chk(input logic [31:0] addr);
    #1;
    check_eq("req.imem_req", {31'd0, imem_req}, 32'd1);
    check_eq("req.imem_addr", imem_addr, addr);
    check_eq("req.pc_write", {31'd0, pc_write}, 32'd1);
    check_eq("req.if_valid", {31'd0, if_valid}, 32'd0);
  endtask

  task automatic resp_chk(input logic [31:0] addr, input logic [31:0] nxt);
    imem_rvalid = 1'b1;
    imem_rdata  = instr_of(addr);
    #1;
    check_eq("resp.if_valid", {31'd0, if_valid}, 32'd1);
    check_eq("resp.if_instr", if_instr, instr_of(addr));
    check_eq("resp.if_pc", if_pc, addr);
    check_eq("resp.pc_next", pc_next, nxt);
  endtask

  initial begin
    reset = 1'b1;
    exc_valid = 1'b0; jump_valid = 1'b0; br_valid = 1'b0; stall = 1'b0;
    jump_target = '0; br_target = '0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    #2;
    check_eq("rst.state", {30'd0, dbg_state}, {30'd0, ST_BOOT});
    check_eq("rst.pc_write", {31'd0, pc_write}, 32'd1);
    check_eq("rst.pc_next", pc_next, 32'h0);
    check_eq("rst.imem_req", {31'd0, imem_req}, 32'd0);
    check_eq("rst.imem_addr", imem_addr, 32'h0);
    check_eq("rst.if_valid", {31'd0, if_valid}, 32'd0);
    check_eq("rst.flush", {31'd0, flush}, 32'd0);
    check_eq("rst.trap", {31'd0, misalign_trap}, 32'd0);

    @(posedge clk); #1 reset = 1'b0; #1;
    check_eq("boot.pc_next", pc_next, 32'h0);
    check_eq("boot.imem_req", {31'd0, imem_req}, 32'd0);

    // Sequential fetch 0, 4, 8
    cyc(); req_chk(32'h0);
    cyc(); resp_chk(32'h0, 32'h4);
    cyc(); req_chk(32'h4);
    cyc(); resp_chk(32'h4, 32'h8);
    cyc(); req_chk(32'h8);

    // Stall for three cycles on the response to 0x8
    cyc(); stall = 1'b1; resp_chk(32'h8, 32'h8);
    for (int i = 0; i < 2; i++) begin
      cyc(); #1;
      check_eq("stall.if_valid", {31'd0, if_valid}, 32'd1);
      check_eq("stall.if_instr", if_instr, instr_of(32'h8));
      check_eq("stall.if_pc", if_pc, 32'h8);
      check_eq("stall.pc_cur", pc_cur, 32'h8);
      check_eq("stall.pc_next", pc_next, 32'h8);
    end
    cyc(); stall = 1'b0; #1;
    check_eq("unstall.if_pc", if_pc, 32'h8);
    check_eq("unstall.pc_next", pc_next, 32'hC);
    cyc(); req_chk(32'hC);
    cyc(); resp_chk(32'hC, 32'h10);
    cyc(); req_chk(32'h10);

    // Jump beats branch, same cycle as the response
    cyc();
    jump_valid = 1'b1; jump_target = 32'h100;
    br_valid = 1'b1; br_target = 32'h200;
    imem_rvalid = 1'b1; imem_rdata = instr_of(32'h10); #1;
    check_eq("prio.pc_next", pc_next, 32'h100);
    check_eq("prio.flush", {31'd0, flush}, 32'd1);
    check_eq("prio.if_valid", {31'd0, if_valid}, 32'd1);
    cyc(); req_chk(32'h100);
    check_eq("prio.flush_once", {31'd0, flush}, 32'd0);

    // Branch in WAIT before rvalid: late response dropped
    cyc(); br_valid = 1'b1; br_target = 32'h40; #1;
    check_eq("late.pc_next", pc_next, 32'h40);
    check_eq("late.flush", {31'd0, flush}, 32'd1);
    check_eq("late.if_valid", {31'd0, if_valid}, 32'd0);
    check_eq("late.state", {30'd0, dbg_state}, {30'd0, ST_WAIT});
    cyc(); imem_rvalid = 1'b1; imem_rdata = instr_of(32'h100); #1;
    check_eq("drop.if_valid", {31'd0, if_valid}, 32'd0);
    check_eq("drop.pc_next", pc_next, 32'h40);
    check_eq("drop.flush", {31'd0, flush}, 32'd0);
    cyc(); req_chk(32'h40);
    cyc(); resp_chk(32'h40, 32'h44);

    // Misaligned jump target, memory not ready so no discard
    cyc(); imem_ready = 1'b0; req_chk(32'h44);
    jump_valid = 1'b1; jump_target = 32'h102; #1;
    check_eq("mis.pc_next", pc_next, EXP_MIS_PC);
    check_eq("mis.flush", {31'd0, flush}, 32'd1);
    check_eq("mis.trap", {31'd0, misalign_trap}, EXP_MIS_TRAP);
    cyc(); req_chk(EXP_MIS_PC);
    check_eq("mis.trap_pulse", {31'd0, misalign_trap}, 32'd0);

    // Exception beats jump while the request is accepted: response discarded
    exc_valid = 1'b1; jump_valid = 1'b1; jump_target = 32'h300; imem_ready = 1'b1; #1;
    check_eq("exc.pc_next", pc_next, 32'h80);
    check_eq("exc.flush", {31'd0, flush}, 32'd1);
    check_eq("exc.trap", {31'd0, misalign_trap}, 32'd0);
    cyc(); imem_rvalid = 1'b1; imem_rdata = instr_of(EXP_MIS_PC); #1;
    check_eq("exc.drop", {31'd0, if_valid}, 32'd0);
    check_eq("exc.hold", pc_next, 32'h80);

    // Wrap at the top of the address space
    cyc(); imem_ready = 1'b0; req_chk(32'h80);
    jump_valid = 1'b1; jump_target = 32'hFFFF_FFFC; #1;
    check_eq("wrap.jump", pc_next, 32'hFFFF_FFFC);
    cyc(); imem_ready = 1'b1; req_chk(32'hFFFF_FFFC);
    cyc(); resp_chk(32'hFFFF_FFFC, 32'h0);
    cyc(); req_chk(32'h0);

    // Reset while waiting; stale rvalid after release is ignored
    cyc(); #1 reset = 1'b1; #1;
    check_eq("rstw.state", {30'd0, dbg_state}, {30'd0, ST_BOOT});
    check_eq("rstw.pc_next", pc_next, 32'h0);
    check_eq("rstw.imem_req", {31'd0, imem_req}, 32'd0);
    #1 reset = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    check_eq("stale.if_valid", {31'd0, if_valid}, 32'd0);
    check_eq("stale.flush", {31'd0, flush}, 32'd0);
    check_eq("stale.pc_next", pc_next, 32'h0);
    cyc(); req_chk(32'h0);
    cyc(); #1;
    check_eq("fresh.if_valid", {31'd0, if_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
